// File: rtl/age_rs_pkg.sv
// Shared constants, op-code encodings and tag helpers for the age-ordered
// reservation station.
package age_rs_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned WORD = 32;

  // A source tag equal to this value means the operand value is already present.
  localparam int unsigned ZERO_ROB_IDX = 0;

  typedef enum logic [5:0] {
    OPT_NONE = 6'd0,
    OPT_ADD  = 6'd1,
    OPT_SUB  = 6'd2,
    OPT_AND  = 6'd3,
    OPT_OR   = 6'd4,
    OPT_XOR  = 6'd5
  } alu_opt_e;

  // True when a valid broadcast carries the tag a pending operand waits on.
  function automatic logic tag_hit(input logic [31:0] tag,
                                   input logic [31:0] cdb_tag,
                                   input logic        cdb_vld);
    return cdb_vld && (tag != 32'(ZERO_ROB_IDX)) && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/age_rs_age_matrix_sel.sv
// Older-than matrix: remembers relative dispatch order of the occupied
// entries and grants the single oldest requesting entry.
module age_matrix_sel
  import age_rs_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             i_clr_all,
  input  logic             i_ins_valid,
  input  logic [IDX_W-1:0] i_ins_idx,
  input  logic [SIZE-1:0]  i_busy,
  input  logic             i_del_valid,
  input  logic [IDX_W-1:0] i_del_idx,
  input  logic [SIZE-1:0]  i_req,
  output logic [SIZE-1:0]  o_grant
);

  // r_older[i][j] set: entry j was dispatched before entry i and is still live.
  logic [SIZE-1:0] r_older [SIZE];
  logic [SIZE-1:0] w_del_oh;

  // One-hot of the entry leaving this cycle, so its column can be wiped.
  always_comb begin
    if (i_del_valid) begin
      w_del_oh = SIZE'(1) << i_del_idx;
    end else begin
      w_del_oh = '0;
    end
  end

  // A new entry is younger than every live entry; a leaving entry stops blocking anyone.
  always_ff @(posedge clk) begin
    if (i_clr_all) begin
      for (int i = 0; i < SIZE; i++) begin
        r_older[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (i_ins_valid && (i_ins_idx == IDX_W'(i))) begin
          r_older[i] <= i_busy & ~w_del_oh;
        end else begin
          r_older[i] <= r_older[i] & ~w_del_oh;
        end
      end
    end
  end

  // Grant a requester only when no older entry is also requesting.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < SIZE; i++) begin
      o_grant[i] = i_req[i] & ~(|(i_req & r_older[i]));
    end
  end

endmodule

// File: rtl/age_rs.sv
// Parametrised out-of-order reservation station: buffers dispatched ALU ops,
// wakes operands from the CDB channels and issues the oldest ready op.
module age_rs
  import age_rs_pkg::*;
#(
  parameter int RS_BIT  = 4,
  parameter int ROB_BIT = 4,
  parameter int CDB_N   = 2,
  parameter int OPT_W   = 6,
  parameter int WORD_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rs_st,
  input  logic                      rs_rb,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [OPT_W-1:0]          id_opt,
  input  logic [ROB_BIT-1:0]        id_src1,
  input  logic [ROB_BIT-1:0]        id_src2,
  input  logic [WORD_W-1:0]         id_val1,
  input  logic [WORD_W-1:0]         id_val2,
  input  logic [WORD_W-1:0]         id_imm,
  input  logic [ROB_BIT-1:0]        id_rob_idx,
  output logic                      alu_valid,
  input  logic                      alu_ready,
  output logic [OPT_W-1:0]          alu_opt,
  output logic [WORD_W-1:0]         alu_val1,
  output logic [WORD_W-1:0]         alu_val2,
  output logic [WORD_W-1:0]         alu_imm,
  output logic [ROB_BIT-1:0]        alu_rob_idx,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*ROB_BIT-1:0]  cdb_src,
  input  logic [CDB_N*WORD_W-1:0]   cdb_val,
  output logic [RS_BIT:0]           rs_count,
  output logic                      rs_empty
);

  localparam int RS_SIZE = 1 << RS_BIT;
  localparam int CNT_W   = RS_BIT + 1;
  localparam logic [ROB_BIT-1:0] ZERO_TAG = ROB_BIT'(ZERO_ROB_IDX);

  // Entry storage
  logic [RS_SIZE-1:0] r_busy;
  logic [OPT_W-1:0]   r_opt  [RS_SIZE];
  logic [ROB_BIT-1:0] r_src1 [RS_SIZE];
  logic [ROB_BIT-1:0] r_src2 [RS_SIZE];
  logic [WORD_W-1:0]  r_val1 [RS_SIZE];
  logic [WORD_W-1:0]  r_val2 [RS_SIZE];
  logic [WORD_W-1:0]  r_imm  [RS_SIZE];
  logic [ROB_BIT-1:0] r_rob  [RS_SIZE];
  logic [CNT_W-1:0]   r_count;

  // ALU output register
  logic               r_alu_valid;
  logic [OPT_W-1:0]   r_alu_opt;
  logic [WORD_W-1:0]  r_alu_val1;
  logic [WORD_W-1:0]  r_alu_val2;
  logic [WORD_W-1:0]  r_alu_imm;
  logic [ROB_BIT-1:0] r_alu_rob;

  logic               w_active;
  logic               w_id_ready;
  logic               w_dispatch;
  logic               w_out_load;
  logic               w_issue;
  logic               w_free_any;
  logic [RS_BIT-1:0]  w_free_idx;
  logic [RS_SIZE-1:0] w_req;
  logic [RS_SIZE-1:0] w_grant;
  logic               w_any_req;
  logic [RS_BIT-1:0]  w_gnt_idx;
  logic [ROB_BIT-1:0] w_cdb_tag [CDB_N];
  logic [WORD_W-1:0]  w_cdb_word [CDB_N];
  logic [ROB_BIT-1:0] w_byp_src1;
  logic [ROB_BIT-1:0] w_byp_src2;
  logic [WORD_W-1:0]  w_byp_val1;
  logic [WORD_W-1:0]  w_byp_val2;
  logic [ROB_BIT-1:0] w_src1_nx [RS_SIZE];
  logic [ROB_BIT-1:0] w_src2_nx [RS_SIZE];
  logic [WORD_W-1:0]  w_val1_nx [RS_SIZE];
  logic [WORD_W-1:0]  w_val2_nx [RS_SIZE];

  assign w_active   = rdy & ~rs_st;
  assign w_id_ready = (r_count != CNT_W'(RS_SIZE));
  assign w_dispatch = id_valid & w_id_ready & w_free_any & w_active;
  assign w_out_load = w_active & (~r_alu_valid | alu_ready);
  assign w_issue    = w_out_load & w_any_req;
  assign w_any_req  = |w_req;

  assign id_ready    = w_id_ready;
  assign rs_count    = r_count;
  assign rs_empty    = (r_count == CNT_W'(0));
  assign alu_valid   = r_alu_valid;
  assign alu_opt     = r_alu_opt;
  assign alu_val1    = r_alu_val1;
  assign alu_val2    = r_alu_val2;
  assign alu_imm     = r_alu_imm;
  assign alu_rob_idx = r_alu_rob;

  // Split the flat CDB buses into per-channel tag/value views.
  always_comb begin
    for (int k = 0; k < CDB_N; k++) begin
      w_cdb_tag[k]  = cdb_src[k*ROB_BIT +: ROB_BIT];
      w_cdb_word[k] = cdb_val[k*WORD_W +: WORD_W];
    end
  end

  // Dispatch bypass: a tag broadcast this cycle is captured as ready; lowest channel wins.
  always_comb begin
    w_byp_src1 = id_src1;
    w_byp_src2 = id_src2;
    w_byp_val1 = id_val1;
    w_byp_val2 = id_val2;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (tag_hit(32'(id_src1), 32'(w_cdb_tag[k]), cdb_valid[k])) begin
        w_byp_src1 = ZERO_TAG;
        w_byp_val1 = w_cdb_word[k];
      end else begin
        w_byp_src1 = w_byp_src1;
      end
      if (tag_hit(32'(id_src2), 32'(w_cdb_tag[k]), cdb_valid[k])) begin
        w_byp_src2 = ZERO_TAG;
        w_byp_val2 = w_cdb_word[k];
      end else begin
        w_byp_src2 = w_byp_src2;
      end
    end
  end

  // Operand wakeup for every stored entry; lowest matching channel wins.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_src1_nx[i] = r_src1[i];
      w_src2_nx[i] = r_src2[i];
      w_val1_nx[i] = r_val1[i];
      w_val2_nx[i] = r_val2[i];
      for (int k = CDB_N - 1; k >= 0; k--) begin
        if (r_busy[i] && tag_hit(32'(r_src1[i]), 32'(w_cdb_tag[k]), cdb_valid[k])) begin
          w_src1_nx[i] = ZERO_TAG;
          w_val1_nx[i] = w_cdb_word[k];
        end else begin
          w_src1_nx[i] = w_src1_nx[i];
        end
        if (r_busy[i] && tag_hit(32'(r_src2[i]), 32'(w_cdb_tag[k]), cdb_valid[k])) begin
          w_src2_nx[i] = ZERO_TAG;
          w_val2_nx[i] = w_cdb_word[k];
        end else begin
          w_src2_nx[i] = w_src2_nx[i];
        end
      end
    end
  end

  // Ready vector from registered tags only, so a wakeup becomes eligible one cycle later.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_req[i] = r_busy[i] & (r_src1[i] == ZERO_TAG) & (r_src2[i] == ZERO_TAG);
    end
  end

  // Lowest-index free entry for dispatch.
  always_comb begin
    w_free_idx = '0;
    w_free_any = FALSE;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = RS_BIT'(i);
        w_free_any = TRUE;
      end else begin
        w_free_any = w_free_any;
      end
    end
  end

  // Encode the one-hot oldest grant into an entry index.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx = RS_BIT'(i);
      end else begin
        w_gnt_idx = w_gnt_idx;
      end
    end
  end

  age_matrix_sel #(
    .SIZE  (RS_SIZE),
    .IDX_W (RS_BIT)
  ) u_age (
    .clk         (clk),
    .i_clr_all   (rst | rs_rb),
    .i_ins_valid (w_dispatch),
    .i_ins_idx   (w_free_idx),
    .i_busy      (r_busy),
    .i_del_valid (w_issue),
    .i_del_idx   (w_gnt_idx),
    .i_req       (w_req),
    .o_grant     (w_grant)
  );

  // Entry updates (wakeup, dispatch, free), occupancy count and ALU output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_count     <= '0;
      r_alu_valid <= FALSE;
      r_alu_opt   <= OPT_W'(OPT_NONE);
      r_alu_val1  <= '0;
      r_alu_val2  <= '0;
      r_alu_imm   <= '0;
      r_alu_rob   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_opt[i]  <= OPT_W'(OPT_NONE);
        r_src1[i] <= ZERO_TAG;
        r_src2[i] <= ZERO_TAG;
        r_val1[i] <= '0;
        r_val2[i] <= '0;
        r_imm[i]  <= '0;
        r_rob[i]  <= '0;
      end
    end else if (rs_rb) begin
      // Flush drops all work but keeps the last ALU payload bits.
      r_busy      <= '0;
      r_count     <= '0;
      r_alu_valid <= FALSE;
    end else begin
      // Wakeup continues even while dispatch/issue are frozen.
      for (int i = 0; i < RS_SIZE; i++) begin
        r_src1[i] <= w_src1_nx[i];
        r_src2[i] <= w_src2_nx[i];
        r_val1[i] <= w_val1_nx[i];
        r_val2[i] <= w_val2_nx[i];
      end
      if (w_issue) begin
        r_busy[w_gnt_idx] <= FALSE;
      end else begin
        r_busy <= r_busy;
      end
      if (w_dispatch) begin
        r_busy[w_free_idx] <= TRUE;
        r_opt[w_free_idx]  <= id_opt;
        r_src1[w_free_idx] <= w_byp_src1;
        r_src2[w_free_idx] <= w_byp_src2;
        r_val1[w_free_idx] <= w_byp_val1;
        r_val2[w_free_idx] <= w_byp_val2;
        r_imm[w_free_idx]  <= id_imm;
        r_rob[w_free_idx]  <= id_rob_idx;
      end else begin
        r_count <= r_count;
      end
      if (w_out_load) begin
        r_alu_valid <= w_any_req;
        if (w_any_req) begin
          r_alu_opt  <= r_opt[w_gnt_idx];
          r_alu_val1 <= r_val1[w_gnt_idx];
          r_alu_val2 <= r_val2[w_gnt_idx];
          r_alu_imm  <= r_imm[w_gnt_idx];
          r_alu_rob  <= r_rob[w_gnt_idx];
        end else begin
          r_alu_rob  <= r_alu_rob;
        end
      end else begin
        r_alu_valid <= r_alu_valid;
      end
      r_count <= r_count + CNT_W'(w_dispatch) - CNT_W'(w_issue);
    end
  end

endmodule

// File: tb/tb_age_rs.sv
// Directed, scoreboard-checked bench for the age-ordered reservation station.
module tb_age_rs;
  import age_rs_pkg::*;

  typedef logic [105:0] item_t;  // {opt, val1, val2, imm, rob}

  logic        clk = 1'b0;
  logic        rst, rdy, rs_st, rs_rb;
  logic        id_valid, id_ready;
  logic [5:0]  id_opt;
  logic [3:0]  id_src1, id_src2, id_rob_idx;
  logic [31:0] id_val1, id_val2, id_imm;
  logic        alu_valid, alu_ready;
  logic [5:0]  alu_opt;
  logic [31:0] alu_val1, alu_val2, alu_imm;
  logic [3:0]  alu_rob_idx;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_src;
  logic [63:0] cdb_val;
  logic [4:0]  rs_count;
  logic        rs_empty;

  int total = 0;
  int bad   = 0;
  item_t sb[$];

  always #5 clk = ~clk;

  age_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_st(rs_st), .rs_rb(rs_rb),
    .id_valid(id_valid), .id_ready(id_ready), .id_opt(id_opt),
    .id_src1(id_src1), .id_src2(id_src2), .id_val1(id_val1), .id_val2(id_val2),
    .id_imm(id_imm), .id_rob_idx(id_rob_idx),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opt(alu_opt),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_rob_idx(alu_rob_idx),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val),
    .rs_count(rs_count), .rs_empty(rs_empty)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic [5:0] opt, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] imm,
                               input logic [3:0] rob);
    return {opt, v1, v2, imm, rob};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] opt, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic [3:0] rob);
    id_opt = opt; id_src1 = s1; id_src2 = s2;
    id_val1 = v1; id_val2 = v2; id_imm = imm; id_rob_idx = rob;
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
  endtask

  task automatic bcast(input int ch, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[ch] = 1'b1;
    cdb_src[ch*4 +: 4] = tag;
    cdb_val[ch*32 +: 32] = val;
    tick();
    cdb_valid = 2'b00;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 300 && (sb.size() != 0 || alu_valid); c++) tick();
    chk(tag, 128'(sb.size()), 128'(0));
  endtask

  // Scoreboard: every completed handshake must match the next expected issue.
  always @(negedge clk) begin
    if (alu_valid && alu_ready && rdy && !rs_st && !rst && !rs_rb) begin
      chk("issue_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        item_t e;
        e = sb.pop_front();
        chk("issue_data", 128'({alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx}), 128'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rs_st = 1'b0; rs_rb = 1'b0; id_valid = 1'b0;
    id_opt = '0; id_src1 = '0; id_src2 = '0; id_val1 = '0; id_val2 = '0;
    id_imm = '0; id_rob_idx = '0; alu_ready = 1'b1;
    cdb_valid = 2'b00; cdb_src = '0; cdb_val = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_alu_valid", 128'(alu_valid), 128'(0));
    chk("rst_id_ready",  128'(id_ready),  128'(1));
    chk("rst_count",     128'(rs_count),  128'(0));
    chk("rst_empty",     128'(rs_empty),  128'(1));
    chk("rst_alu_data",  128'({alu_opt, alu_val1, alu_rob_idx}), 128'(0));

    // Ready op: one-cycle select latency
    sb.push_back(mk(OPT_ADD, 32'd3, 32'd4, 32'd0, 4'd5));
    dispatch(OPT_ADD, 4'd0, 4'd0, 32'd3, 32'd4, 32'd0, 4'd5);
    chk("add_count1", 128'(rs_count), 128'(1));
    chk("add_valid_e0", 128'(alu_valid), 128'(0));
    tick();
    chk("add_valid_e1", 128'(alu_valid), 128'(1));
    chk("add_count0", 128'(rs_count), 128'(0));
    tick();
    chk("add_valid_done", 128'(alu_valid), 128'(0));
    chk("add_empty", 128'(rs_empty), 128'(1));

    // Waiting A, ready B, wake A on channel 1
    sb.push_back(mk(OPT_ADD, 32'd10, 32'd20, 32'd0, 4'd2));
    sb.push_back(mk(OPT_SUB, 32'h55, 32'd2, 32'd0, 4'd1));
    dispatch(OPT_SUB, 4'd7, 4'd0, 32'd0, 32'd2, 32'd0, 4'd1);
    dispatch(OPT_ADD, 4'd0, 4'd0, 32'd10, 32'd20, 32'd0, 4'd2);
    chk("ab_count", 128'(rs_count), 128'(2));
    bcast(1, 4'd7, 32'h55);
    drain("ab_drain");

    // Dispatch bypass with the same tag on both channels: channel 0 wins
    sb.push_back(mk(OPT_AND, 32'hA0, 32'hA0, 32'h1, 4'd6));
    cdb_valid = 2'b11; cdb_src = {4'd6, 4'd6}; cdb_val = {32'hB0, 32'hA0};
    dispatch(OPT_AND, 4'd6, 4'd6, 32'd0, 32'd0, 32'h1, 4'd6);
    cdb_valid = 2'b00;
    drain("byp_drain");

    // Both wait on tag 3; older B must issue first
    sb.push_back(mk(OPT_ADD, 32'd1, 32'h33, 32'd0, 4'd4));
    sb.push_back(mk(OPT_SUB, 32'h33, 32'd2, 32'd0, 4'd3));
    dispatch(OPT_ADD, 4'd0, 4'd3, 32'd1, 32'd0, 32'd0, 4'd4);
    dispatch(OPT_SUB, 4'd3, 4'd0, 32'd0, 32'd2, 32'd0, 4'd3);
    bcast(0, 4'd3, 32'h33);
    drain("age_drain");

    // Fill: 14 waiting, one ready, then same-edge dispatch+issue, then full
    for (int i = 0; i < 14; i++)
      dispatch(OPT_XOR, 4'd9, 4'd0, 32'd0, 32'(i), 32'd0, 4'(i));
    sb.push_back(mk(OPT_OR, 32'h11, 32'h22, 32'h33, 4'd14));
    dispatch(OPT_OR, 4'd0, 4'd0, 32'h11, 32'h22, 32'h33, 4'd14);
    chk("fill_count15", 128'(rs_count), 128'(15));
    dispatch(OPT_XOR, 4'd9, 4'd0, 32'd0, 32'd15, 32'd0, 4'd15);
    chk("same_edge_count", 128'(rs_count), 128'(15));
    chk("same_edge_valid", 128'(alu_valid), 128'(1));
    dispatch(OPT_XOR, 4'd9, 4'd0, 32'd0, 32'h10, 32'd0, 4'd0);
    chk("full_count", 128'(rs_count), 128'(16));
    chk("full_id_ready", 128'(id_ready), 128'(0));
    dispatch(OPT_ADD, 4'd0, 4'd0, 32'hDEAD, 32'd0, 32'd0, 4'd3);
    chk("full_dropped", 128'(rs_count), 128'(16));
    tick();
    chk("full_idle", 128'(alu_valid), 128'(0));
    for (int i = 0; i < 14; i++) sb.push_back(mk(OPT_XOR, 32'h99, 32'(i), 32'd0, 4'(i)));
    sb.push_back(mk(OPT_XOR, 32'h99, 32'd15, 32'd0, 4'd15));
    sb.push_back(mk(OPT_XOR, 32'h99, 32'h10, 32'd0, 4'd0));
    bcast(0, 4'd9, 32'h99);
    drain("fill_drain");

    // Back-pressure hold, then wakeup during stall
    alu_ready = 1'b0;
    sb.push_back(mk(OPT_SUB, 32'h70, 32'h71, 32'd0, 4'd7));
    dispatch(OPT_SUB, 4'd0, 4'd0, 32'h70, 32'h71, 32'd0, 4'd7);
    dispatch(OPT_ADD, 4'd4, 4'd0, 32'd0, 32'h72, 32'd0, 4'd8);
    for (int c = 0; c < 3; c++) begin
      chk("hold_valid", 128'(alu_valid), 128'(1));
      chk("hold_data", 128'({alu_val1, alu_val2, alu_rob_idx}), 128'({32'h70, 32'h71, 4'd7}));
      tick();
    end
    alu_ready = 1'b1;
    tick();
    chk("hold_released", 128'(alu_valid), 128'(0));
    sb.push_back(mk(OPT_ADD, 32'h44, 32'h72, 32'd0, 4'd8));
    rs_st = 1'b1;
    bcast(1, 4'd4, 32'h44);
    chk("stall_valid1", 128'(alu_valid), 128'(0));
    tick();
    chk("stall_valid2", 128'(alu_valid), 128'(0));
    rs_st = 1'b0;
    drain("stall_drain");

    // Flush with work pending and a same-edge dispatch request
    alu_ready = 1'b0;
    for (int i = 1; i <= 6; i++)
      dispatch(OPT_ADD, 4'd0, 4'd0, 32'(i), 32'd0, 32'd0, 4'(i));
    chk("preflush_valid", 128'(alu_valid), 128'(1));
    chk("preflush_count", 128'(rs_count), 128'(5));
    rs_rb = 1'b1;
    dispatch(OPT_ADD, 4'd0, 4'd0, 32'hF0, 32'd0, 32'd0, 4'd12);
    rs_rb = 1'b0;
    chk("flush_empty", 128'(rs_empty), 128'(1));
    chk("flush_valid", 128'(alu_valid), 128'(0));
    chk("flush_id_ready", 128'(id_ready), 128'(1));
    alu_ready = 1'b1;
    tick(); tick();
    chk("flush_nothing_written", 128'({alu_valid, rs_count}), 128'(0));

    // Reset in the middle of a handshake
    alu_ready = 1'b0;
    dispatch(OPT_ADD, 4'd0, 4'd0, 32'h90, 32'd0, 32'd0, 4'd9);
    tick();
    chk("prerst_valid", 128'(alu_valid), 128'(1));
    rst = 1'b1; alu_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 128'(alu_valid), 128'(0));
    chk("midrst_data", 128'({alu_val1, alu_rob_idx, rs_count}), 128'(0));

    drain("final_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
